// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - coin payout engine with greedy exact-change planning and tube inventory
module change_dispenser #(
  parameter int INIT_1 = 3,
  parameter int INIT_2 = 3,
  parameter int INIT_4 = 3,
  parameter int GAP    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] change_amount,
  input  logic       refill,
  input  logic [1:0] refill_denom,
  input  logic [3:0] refill_count,
  output logic       ready,
  output logic       coin_valid,
  output logic [1:0] coin_denom,
  output logic       done,
  output logic       red_light,
  output logic [3:0] remaining,
  output logic [3:0] stock_1,
  output logic [3:0] stock_2,
  output logic [3:0] stock_4
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_EJECT, S_WAIT, S_DONE} state_t;

  state_t     state;
  logic [3:0] plan_4, plan_2, plan_1;
  logic [2:0] wait_cnt;

  logic [3:0] chk_q4, chk_n4, chk_r1, chk_q2, chk_n2, chk_r2, chk_n1, chk_r;
  logic [3:0] ej_4, ej_2, ej_1, coin_val;
  logic [3:0] ref_cur, ref_sat;
  logic [4:0] ref_sum;

  // Largest denomination that still has coins left in a plan.
  function automatic logic [1:0] pick(input logic [3:0] a4, input logic [3:0] a2,
                                      input logic [3:0] a1);
    if (a4 != 4'd0)      return 2'b11;
    else if (a2 != 4'd0) return 2'b10;
    else if (a1 != 4'd0) return 2'b01;
    else                 return 2'b00;
  endfunction

  // Greedy plan from the latched amount, post-eject plan, and saturating refill sum.
  always_comb begin
    chk_q4 = remaining >> 2;
    chk_n4 = (stock_4 < chk_q4) ? stock_4 : chk_q4;
    chk_r1 = remaining - {chk_n4[1:0], 2'b00};
    chk_q2 = chk_r1 >> 1;
    chk_n2 = (stock_2 < chk_q2) ? stock_2 : chk_q2;
    chk_r2 = chk_r1 - {chk_n2[2:0], 1'b0};
    chk_n1 = (stock_1 < chk_r2) ? stock_1 : chk_r2;
    chk_r  = chk_r2 - chk_n1;

    ej_4     = plan_4;
    ej_2     = plan_2;
    ej_1     = plan_1;
    coin_val = 4'd0;
    case (coin_denom)
      2'b11:   begin ej_4 = plan_4 - 4'd1; coin_val = 4'd4; end
      2'b10:   begin ej_2 = plan_2 - 4'd1; coin_val = 4'd2; end
      2'b01:   begin ej_1 = plan_1 - 4'd1; coin_val = 4'd1; end
      default: ;
    endcase

    case (refill_denom)
      2'b01:   ref_cur = stock_1;
      2'b10:   ref_cur = stock_2;
      2'b11:   ref_cur = stock_4;
      default: ref_cur = 4'd0;
    endcase
    ref_sum = {1'b0, ref_cur} + {1'b0, refill_count};
    ref_sat = ref_sum[4] ? 4'hF : ref_sum[3:0];
  end

  // Payout FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ready      <= 1'b1;
      coin_valid <= 1'b0;
      coin_denom <= 2'b00;
      done       <= 1'b0;
      red_light  <= 1'b0;
      remaining  <= 4'd0;
      stock_1    <= 4'(INIT_1);
      stock_2    <= 4'(INIT_2);
      stock_4    <= 4'(INIT_4);
      plan_4     <= 4'd0;
      plan_2     <= 4'd0;
      plan_1     <= 4'd0;
      wait_cnt   <= 3'd0;
    end else begin
      coin_valid <= 1'b0;
      coin_denom <= 2'b00;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            remaining <= change_amount;
            red_light <= 1'b0;
            ready     <= 1'b0;
            state     <= S_CHECK;
          end else if (refill) begin
            case (refill_denom)
              2'b01:   stock_1 <= ref_sat;
              2'b10:   stock_2 <= ref_sat;
              2'b11:   stock_4 <= ref_sat;
              default: ;
            endcase
          end
        end
        S_CHECK: begin
          plan_4 <= chk_n4;
          plan_2 <= chk_n2;
          plan_1 <= chk_n1;
          if (chk_r != 4'd0) begin
            red_light <= 1'b1;
            remaining <= 4'd0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (remaining == 4'd0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            coin_valid <= 1'b1;
            coin_denom <= pick(chk_n4, chk_n2, chk_n1);
            state      <= S_EJECT;
          end
        end
        S_EJECT: begin
          plan_4    <= ej_4;
          plan_2    <= ej_2;
          plan_1    <= ej_1;
          remaining <= remaining - coin_val;
          case (coin_denom)
            2'b11:   stock_4 <= stock_4 - 4'd1;
            2'b10:   stock_2 <= stock_2 - 4'd1;
            2'b01:   stock_1 <= stock_1 - 4'd1;
            default: ;
          endcase
          if ((ej_4 | ej_2 | ej_1) == 4'd0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (GAP == 0) begin
            coin_valid <= 1'b1;
            coin_denom <= pick(ej_4, ej_2, ej_1);
            state      <= S_EJECT;
          end else begin
            wait_cnt <= 3'(GAP - 1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            coin_valid <= 1'b1;
            coin_denom <= pick(plan_4, plan_2, plan_1);
            state      <= S_EJECT;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_DONE: begin
          remaining <= 4'd0;
          ready     <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
